// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS32 pipeline plus the MEM/WB register.
// Loads/stores go out over a req/ack handshake; the pipeline stalls until
// ack or timeout. Load data is lane-aligned and extended before write-back.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Valid_MEM,
  input  logic [31:0] ALU_Result_MEM,
  input  logic [31:0] Write_Data_MEM,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic [1:0]  MemSize_MEM,
  input  logic        MemSigned_MEM,
  input  logic        MemtoReg_MEM,
  input  logic        RegWrite_MEM,
  input  logic [4:0]  Write_Reg_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        Stall_MEM,
  output logic        Misaligned_MEM,
  output logic        Bus_Error,
  output logic [31:0] ALU_Result_WB,
  output logic [31:0] Read_Data_WB,
  output logic        MemtoReg_WB,
  output logic        RegWrite_WB,
  output logic [4:0]  Write_Reg_WB
);
  // A zero timeout still needs a legal (1-bit) counter.
  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);
  localparam logic TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t r_state, w_next;

  logic [CW-1:0] r_cnt;
  logic [31:0]   r_addr, r_wdata;
  logic [3:0]    r_be;
  logic [1:0]    r_size, r_lane;
  logic          r_we, r_signed, r_bus_err;

  logic          w_access, w_misal, w_start, w_ack, w_timeout;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata, w_load;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;

  assign w_access  = Valid_MEM & (MemRead_MEM | MemWrite_MEM);
  assign w_start   = (r_state == S_IDLE) & w_access & ~w_misal;
  assign w_ack     = (r_state == S_WAIT) & dmem_ack;
  assign w_timeout = (r_state == S_WAIT) & ~dmem_ack & TO_EN & (r_cnt == TO_VAL);

  // Alignment check and request encoding from the incoming address/size.
  always_comb begin
    w_misal = 1'b0;
    w_be    = 4'b1111;
    w_wdata = Write_Data_MEM;
    case (MemSize_MEM)
      2'b00: begin
        w_be    = 4'b0001 << ALU_Result_MEM[1:0];
        w_wdata = {4{Write_Data_MEM[7:0]}};
      end
      2'b01: begin
        w_misal = ALU_Result_MEM[0];
        w_be    = ALU_Result_MEM[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{Write_Data_MEM[15:0]}};
      end
      default: w_misal = |ALU_Result_MEM[1:0];
    endcase
  end

  // Next-state logic: IDLE launches aligned accesses, WAIT ends on ack or timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next = S_WAIT;
      S_WAIT: if (dmem_ack || w_timeout) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, wait counter and the latched request (held stable through WAIT).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_size    <= '0;
      r_lane    <= '0;
      r_we      <= 1'b0;
      r_signed  <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_bus_err <= w_timeout;
      if ((r_state == S_WAIT) && !dmem_ack && !w_timeout) r_cnt <= r_cnt + 1'b1;
      else                                                r_cnt <= '0;
      if (w_start) begin
        r_addr   <= {ALU_Result_MEM[31:2], 2'b00};
        r_lane   <= ALU_Result_MEM[1:0];
        r_wdata  <= w_wdata;
        r_be     <= w_be;
        r_we     <= MemWrite_MEM;
        r_size   <= MemSize_MEM;
        r_signed <= MemSigned_MEM;
      end
    end
  end

  // Select the addressed lane of the returned word and extend it.
  always_comb begin
    w_byte = dmem_rdata[7:0];
    case (r_lane)
      2'd1:    w_byte = dmem_rdata[15:8];
      2'd2:    w_byte = dmem_rdata[23:16];
      2'd3:    w_byte = dmem_rdata[31:24];
      default: w_byte = dmem_rdata[7:0];
    endcase
    w_half = r_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_size)
      2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load = dmem_rdata;
    endcase
  end

  // MEM/WB register: non-memory ops pass straight through, memory ops land on
  // ack, everything else (stall, misalign, timeout) becomes a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ALU_Result_WB <= '0;
      Read_Data_WB  <= '0;
      MemtoReg_WB   <= 1'b0;
      RegWrite_WB   <= 1'b0;
      Write_Reg_WB  <= '0;
    end else if ((r_state == S_IDLE) && !w_access) begin
      ALU_Result_WB <= ALU_Result_MEM;
      Read_Data_WB  <= '0;
      MemtoReg_WB   <= MemtoReg_MEM & Valid_MEM;
      RegWrite_WB   <= RegWrite_MEM & Valid_MEM;
      Write_Reg_WB  <= Write_Reg_MEM;
    end else if (w_ack) begin
      ALU_Result_WB <= ALU_Result_MEM;
      Read_Data_WB  <= r_we ? 32'h0 : w_load;
      MemtoReg_WB   <= MemtoReg_MEM;
      RegWrite_WB   <= RegWrite_MEM;
      Write_Reg_WB  <= Write_Reg_MEM;
    end else begin
      MemtoReg_WB   <= 1'b0;
      RegWrite_WB   <= 1'b0;
    end
  end

  assign dmem_req       = (r_state == S_WAIT);
  assign dmem_we        = dmem_req & r_we;
  assign dmem_be        = dmem_req ? r_be : 4'b0000;
  assign dmem_addr      = r_addr;
  assign dmem_wdata     = r_wdata;
  assign Stall_MEM      = w_start | ((r_state == S_WAIT) & ~dmem_ack & ~w_timeout);
  assign Misaligned_MEM = (r_state == S_IDLE) & w_access & w_misal;
  assign Bus_Error      = r_bus_err;
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus randomized ops against
// an arithmetic reference of the lane/extension/byte-enable rules.
module tb_mem_access_stage;
  localparam int TO = 4;

  logic        clk = 1'b0, reset;
  logic        Valid_MEM, MemRead_MEM, MemWrite_MEM, MemSigned_MEM, MemtoReg_MEM, RegWrite_MEM;
  logic [31:0] ALU_Result_MEM, Write_Data_MEM, dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] ALU_Result_WB, Read_Data_WB;
  logic [1:0]  MemSize_MEM;
  logic [4:0]  Write_Reg_MEM, Write_Reg_WB;
  logic        dmem_req, dmem_we, dmem_ack, Stall_MEM, Misaligned_MEM, Bus_Error;
  logic        MemtoReg_WB, RegWrite_WB;
  logic [3:0]  dmem_be;

  int n_pass = 0, n_total = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .Valid_MEM(Valid_MEM), .ALU_Result_MEM(ALU_Result_MEM),
    .Write_Data_MEM(Write_Data_MEM), .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
    .MemSize_MEM(MemSize_MEM), .MemSigned_MEM(MemSigned_MEM), .MemtoReg_MEM(MemtoReg_MEM),
    .RegWrite_MEM(RegWrite_MEM), .Write_Reg_MEM(Write_Reg_MEM), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .Stall_MEM(Stall_MEM),
    .Misaligned_MEM(Misaligned_MEM), .Bus_Error(Bus_Error), .ALU_Result_WB(ALU_Result_WB),
    .Read_Data_WB(Read_Data_WB), .MemtoReg_WB(MemtoReg_WB), .RegWrite_WB(RegWrite_WB),
    .Write_Reg_WB(Write_Reg_WB)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input logic sg);
    longint unsigned v;
    if (sz == 2'd0) begin
      v = (w >> (8 * (a % 4))) % 256;
      if (sg && v >= 128) v = v + 64'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = (w >> (((a % 4) >= 2) ? 16 : 0)) % 65536;
      if (sg && v >= 32768) v = v + 64'hFFFF0000;
    end else v = w;
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_be(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd0) return 4'(1 << (a % 4));
    if (sz == 2'd1) return ((a % 4) >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input logic [1:0] sz);
    if (sz == 2'd0) return (d % 256) * 32'h01010101;
    if (sz == 2'd1) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  function automatic bit ref_misal(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'd1 && (a % 2) != 0) || (sz >= 2'd2 && (a % 4) != 0);
  endfunction

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    Valid_MEM = 0; MemRead_MEM = 0; MemWrite_MEM = 0; MemSize_MEM = 0; MemSigned_MEM = 0;
    MemtoReg_MEM = 0; RegWrite_MEM = 0; Write_Reg_MEM = 0; ALU_Result_MEM = 0;
    Write_Data_MEM = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  // Non-memory op: must reach WB one edge later with no stall.
  task automatic do_alu_op(input logic [31:0] val, input logic [4:0] rd, input logic rw);
    Valid_MEM = 1; MemRead_MEM = 0; MemWrite_MEM = 0; MemtoReg_MEM = 0;
    RegWrite_MEM = rw; Write_Reg_MEM = rd; ALU_Result_MEM = val; dmem_ack = 0;
    #4;
    n_total++; if (Stall_MEM !== 1'b0 || dmem_req !== 1'b0) $display("FAIL alu_nostall: stall=%b req=%b want 0/0", Stall_MEM, dmem_req); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (ALU_Result_WB !== val || RegWrite_WB !== rw || Write_Reg_WB !== rd)
      $display("FAIL alu_wb: got %h/%b/%0d want %h/%b/%0d", ALU_Result_WB, RegWrite_WB, Write_Reg_WB, val, rw, rd);
    else n_pass++;
  endtask

  // Memory op acked in WAIT cycle k (k > TO+1 means never acked -> timeout).
  // Called at posedge+1; returns at posedge+1 of the following cycle.
  task automatic do_mem_op(input string nm, input logic [31:0] a, input logic [31:0] d,
                           input bit ld, input logic [1:0] sz, input bit sg, input logic [4:0] rd,
                           input logic rw, input int k, input logic [31:0] rdata);
    int stalls;
    Valid_MEM = 1; MemRead_MEM = ld; MemWrite_MEM = !ld; MemSize_MEM = sz; MemSigned_MEM = sg;
    MemtoReg_MEM = ld; RegWrite_MEM = rw; Write_Reg_MEM = rd; ALU_Result_MEM = a;
    Write_Data_MEM = d; dmem_ack = 0;
    #4;
    if (ref_misal(a, sz)) begin
      n_total++; if (Misaligned_MEM !== 1'b1 || Stall_MEM !== 1'b0 || dmem_req !== 1'b0)
        $display("FAIL %s misal: mis=%b stall=%b req=%b want 1/0/0", nm, Misaligned_MEM, Stall_MEM, dmem_req);
      else n_pass++;
      @(posedge clk); #1;
      n_total++; if (RegWrite_WB !== 1'b0 || dmem_req !== 1'b0) $display("FAIL %s misal_wb: rw=%b req=%b want 0/0", nm, RegWrite_WB, dmem_req); else n_pass++;
      return;
    end
    n_total++; if (Stall_MEM !== 1'b1 || Misaligned_MEM !== 1'b0 || dmem_req !== 1'b0)
      $display("FAIL %s issue: stall=%b mis=%b req=%b want 1/0/0", nm, Stall_MEM, Misaligned_MEM, dmem_req);
    else n_pass++;
    stalls = 1;
    for (int c = 1; c <= TO + 1; c++) begin
      @(posedge clk); #1;
      n_total++; if (dmem_req !== 1'b1 || dmem_addr !== a - (a % 4) || dmem_be !== ref_be(a, sz) ||
                     dmem_wdata !== ref_wdata(d, sz) || dmem_we !== !ld || RegWrite_WB !== 1'b0)
        $display("FAIL %s req_c%0d: req=%b addr=%h be=%b wd=%h we=%b rwwb=%b want 1/%h/%b/%h/%b/0", nm, c,
                 dmem_req, dmem_addr, dmem_be, dmem_wdata, dmem_we, RegWrite_WB,
                 a - (a % 4), ref_be(a, sz), ref_wdata(d, sz), !ld);
      else n_pass++;
      if (c == k) begin
        dmem_ack = 1; dmem_rdata = rdata; #4;
        n_total++; if (Stall_MEM !== 1'b0) $display("FAIL %s ack_stall: got %b want 0", nm, Stall_MEM); else n_pass++;
        @(posedge clk); #1;
        idle_inputs();
        n_total++; if (RegWrite_WB !== rw || MemtoReg_WB !== ld || Write_Reg_WB !== rd || ALU_Result_WB !== a ||
                       Read_Data_WB !== (ld ? ref_load(rdata, a, sz, sg) : 32'h0) || Bus_Error !== 1'b0)
          $display("FAIL %s wb: rw=%b m2r=%b rd=%0d alu=%h data=%h be=%b want %b/%b/%0d/%h/%h/0", nm,
                   RegWrite_WB, MemtoReg_WB, Write_Reg_WB, ALU_Result_WB, Read_Data_WB, Bus_Error,
                   rw, ld, rd, a, ld ? ref_load(rdata, a, sz, sg) : 32'h0);
        else n_pass++;
        n_total++; if (stalls != k) $display("FAIL %s stall_len: got %0d want %0d", nm, stalls, k); else n_pass++;
        return;
      end else if (c == TO + 1) begin
        #4;
        n_total++; if (Stall_MEM !== 1'b0) $display("FAIL %s to_stall: got %b want 0", nm, Stall_MEM); else n_pass++;
        @(posedge clk); #1;
        idle_inputs();
        n_total++; if (Bus_Error !== 1'b1 || dmem_req !== 1'b0 || RegWrite_WB !== 1'b0)
          $display("FAIL %s timeout: berr=%b req=%b rw=%b want 1/0/0", nm, Bus_Error, dmem_req, RegWrite_WB);
        else n_pass++;
        n_total++; if (stalls != TO + 1) $display("FAIL %s to_len: got %0d want %0d", nm, stalls, TO + 1); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (Bus_Error !== 1'b0) $display("FAIL %s berr_pulse: got %b want 0", nm, Bus_Error); else n_pass++;
        return;
      end else begin
        #4;
        n_total++; if (Stall_MEM !== 1'b1) $display("FAIL %s wait_stall_c%0d: got %b want 1", nm, c, Stall_MEM); else n_pass++;
        stalls++;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1; idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (dmem_req !== 0 || dmem_we !== 0 || dmem_be !== 0 || Bus_Error !== 0 || Stall_MEM !== 0 ||
                   ALU_Result_WB !== 0 || Read_Data_WB !== 0 || MemtoReg_WB !== 0 || RegWrite_WB !== 0 || Write_Reg_WB !== 0)
      $display("FAIL reset_state: req=%b we=%b be=%b berr=%b alu=%h rd=%h rw=%b", dmem_req, dmem_we, dmem_be,
               Bus_Error, ALU_Result_WB, Read_Data_WB, RegWrite_WB);
    else n_pass++;
    reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait();
    Valid_MEM = 1; MemRead_MEM = 1; MemSize_MEM = 2; MemtoReg_MEM = 1; RegWrite_MEM = 1;
    Write_Reg_MEM = 5'd9; ALU_Result_MEM = 32'h0000_4000; dmem_ack = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_total++; if (dmem_req !== 1'b1) $display("FAIL rstwait_req_before: got %b want 1", dmem_req); else n_pass++;
    #2 reset = 1; #1;
    n_total++; if (dmem_req !== 1'b0 || RegWrite_WB !== 1'b0) $display("FAIL rstwait_async: req=%b rw=%b want 0/0", dmem_req, RegWrite_WB); else n_pass++;
    idle_inputs();
    @(posedge clk); #1 reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_total++; if (RegWrite_WB !== 1'b0 || dmem_req !== 1'b0) $display("FAIL rstwait_after%0d: rw=%b req=%b want 0/0", i, RegWrite_WB, dmem_req); else n_pass++;
    end
  endtask

  task automatic test_load_ext();
    do_mem_op("lb",  32'h1003, 0, 1, 2'd0, 1, 5'd3, 1, 1, 32'h80FF1234);
    n_total++; if (Read_Data_WB !== 32'hFFFFFF80) $display("FAIL lb_value: got %h want ffffff80", Read_Data_WB); else n_pass++;
    do_mem_op("lbu", 32'h1003, 0, 1, 2'd0, 0, 5'd4, 1, 1, 32'h80FF1234);
    n_total++; if (Read_Data_WB !== 32'h00000080) $display("FAIL lbu_value: got %h want 00000080", Read_Data_WB); else n_pass++;
    do_mem_op("lh",  32'h1002, 0, 1, 2'd1, 1, 5'd5, 1, 2, 32'h80FF1234);
    do_mem_op("lhu", 32'h1000, 0, 1, 2'd1, 0, 5'd6, 1, 1, 32'h0000F00D);
  endtask

  task automatic test_store();
    Valid_MEM = 1; MemWrite_MEM = 1; MemRead_MEM = 0; MemSize_MEM = 2'd1; ALU_Result_MEM = 32'h2002;
    Write_Data_MEM = 32'h0000BEEF; RegWrite_MEM = 0; MemtoReg_MEM = 0; dmem_ack = 0;
    @(posedge clk); #1;
    n_total++; if (dmem_be !== 4'b1100 || dmem_wdata !== 32'hBEEFBEEF || dmem_addr !== 32'h2000 || dmem_we !== 1'b1)
      $display("FAIL sh_fields: be=%b wd=%h addr=%h we=%b want 1100/beefbeef/00002000/1", dmem_be, dmem_wdata, dmem_addr, dmem_we);
    else n_pass++;
    dmem_ack = 1; @(posedge clk); #1; idle_inputs();
    do_mem_op("sb", 32'h2001, 32'h12345678, 0, 2'd0, 0, 5'd0, 0, 3, 0);
    do_mem_op("sw", 32'h2004, 32'hCAFEF00D, 0, 2'd2, 0, 5'd0, 0, 1, 0);
  endtask

  task automatic test_long_wait();
    do_mem_op("lw4", 32'h3000, 0, 1, 2'd2, 0, 5'd7, 1, 4, 32'hDEADBEEF);
    @(posedge clk); #1;
    n_total++; if (RegWrite_WB !== 1'b0) $display("FAIL lw4_single_write: rw=%b want 0", RegWrite_WB); else n_pass++;
  endtask

  task automatic test_misaligned();
    do_mem_op("lw_mis", 32'h1002, 0, 1, 2'd2, 0, 5'd8, 1, 1, 0);
    do_alu_op(32'h0000_00AA, 5'd10, 1);
    do_mem_op("sh_mis", 32'h1001, 32'h5555, 0, 2'd1, 0, 5'd0, 0, 1, 0);
    idle_inputs();
  endtask

  task automatic test_timeout();
    do_mem_op("lw_to", 32'h5000, 0, 1, 2'd2, 0, 5'd11, 1, 100, 0);
  endtask

  task automatic test_idle_ack();
    idle_inputs(); dmem_ack = 1; dmem_rdata = 32'hFFFF_FFFF;
    #4;
    n_total++; if (dmem_req !== 1'b0 || Stall_MEM !== 1'b0) $display("FAIL idle_ack: req=%b stall=%b want 0/0", dmem_req, Stall_MEM); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (RegWrite_WB !== 1'b0) $display("FAIL idle_ack_wb: rw=%b want 0", RegWrite_WB); else n_pass++;
    dmem_ack = 0;
  endtask

  task automatic test_back_to_back();
    do_alu_op(32'h1111_0000, 5'd1, 1);
    do_mem_op("b2b_lw", 32'h6000, 0, 1, 2'd2, 0, 5'd2, 1, 1, 32'h0BAD_F00D);
    do_alu_op(32'h2222_0000, 5'd3, 1);
    do_mem_op("b2b_lh", 32'h6002, 0, 1, 2'd1, 1, 5'd4, 1, 1, 32'h8001_0000);
    do_alu_op(32'h3333_0000, 5'd5, 0);
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int kind = $urandom_range(0, 2);
      logic [31:0] a = $urandom;
      logic [1:0]  sz = 2'($urandom_range(0, 3));
      logic [4:0]  rd = 5'($urandom_range(0, 31));
      if (kind == 0) do_alu_op(a, rd, 1'($urandom_range(0, 1)));
      else if (kind == 1)
        do_mem_op("rnd_ld", a, 0, 1, sz, 1'($urandom_range(0, 1)), rd, 1, $urandom_range(1, TO + 2), $urandom);
      else
        do_mem_op("rnd_st", a, $urandom, 0, sz, 0, rd, 1'($urandom_range(0, 1)), $urandom_range(1, TO + 2), 0);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_reset_mid_wait();
    test_load_ext();
    test_store();
    test_long_wait();
    test_misaligned();
    test_timeout();
    test_idle_ack();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
